snes_serializer: RTL
====================

Name: snes_serializer

Overview:
- Sits directly downstream of the button-source arbiter.
- Takes the arbitrated 4-bit button code and presents it to the SNES console as a standard controller.
- Answers the console's latch/clock poll with the 16-bit active-low serial stream on the data line.
- Synchronises the console strobes, stretches short presses across frames, and recovers from aborted or stalled polls.

Parameters:
- SYNC_STAGES, 2: flops in each console-input synchroniser (min 2).
- HOLD_FRAMES, 2: extra latch frames a decoded press stays reported after the code returns to "none".
- TIMEOUT_CYCLES, 2048: clk cycles with no clock rising edge in SHIFT before abort (about 170 us at 12 MHz).

Ports:
- clk, input, 1: system clock, 12 MHz nominal.
- reset_n, input, 1: asynchronous active-low reset.
- button_press, input, 4: arbitrated button code, sampled once per frame.
- snes_latch, input, 1: console latch, async, active-high.
- snes_clock, input, 1: console data clock, async, idles high.
- snes_data, output, 1: serial data to console, active-low (0 = pressed).
- frame_strobe, output, 1: one-cycle pulse when latch falls (frame start).
- shifting, output, 1: high while in SHIFT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, snes_data=1, frame_strobe=0, shifting=0.
  - Shift register=0, hold_cnt=0, held_vec=0.
  - Latch sync chain=0; clock sync chain=1.
- Synchronisers:
  - latch_s and clock_s are the SYNC_STAGES-flop outputs.
  - Edges come from a further registered copy of each.
  - All edge-driven updates land 1 clk after the detected edge.
  - Total pin-to-data latency is SYNC_STAGES+1 clk.
- Decode:
  - Codes 1..12 map one-hot to bit (code-1) of a 12-bit vector.
  - Bit order: B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R.
  - Codes 0 and 13..15 decode to "none".
- Hold (evaluated once, on latch_s rising edge):
  - If code is valid: held_vec=decode, hold_cnt=HOLD_FRAMES.
  - Else if hold_cnt>0: held_vec unchanged, hold_cnt decrements.
  - Else: held_vec=0.
  - The 16-bit shift register loads {4'b0000, held_vec}, with 1 = pressed.
  - Bits 12..15 always read as released.
- FSM:
  - IDLE: snes_data=1. On latch_s rise: go to LOAD.
  - LOAD:
    - snes_data = ~sr[0] (bit 0 presented).
    - Clock edges are ignored while latch_s is high.
    - On latch_s fall: go to SHIFT, bit_cnt=0, frame_strobe=1 for one cycle.
  - SHIFT:
    - On each clock_s rising edge: sr <= {1'b1, sr[15:1]}, snes_data <= ~next sr[0], bit_cnt++, timeout counter cleared.
    - On the 16th rising edge (bit_cnt reaches 16): go to DONE; snes_data becomes 0 from the fill.
    - Falling clock edges have no effect.
  - DONE: snes_data=0 (standard controller behaviour). On latch_s rise: go to LOAD.
  - Timeout: in SHIFT, TIMEOUT_CYCLES consecutive clk with no clock_s rise sends the FSM to IDLE; snes_data=1, held_vec retained.
- Simultaneous events and boundaries:
  - A latch_s rise in any state, including mid-SHIFT, aborts the frame and goes to LOAD with a fresh hold evaluation. This takes priority over a same-cycle clock edge.
  - A latch and clock edge detected in the same clk: the latch wins.
  - More than 16 clocks: extra edges in DONE are ignored and data stays 0.
  - Fewer than 16 clocks followed by a new latch: restart cleanly.
  - hold_cnt saturates at 0 and never wraps.
  - button_press changes mid-frame do not affect the frame in flight.
- shifting = (state==SHIFT), registered.

Test Plan:
- Reset, no latch -> snes_data=1, frame_strobe=0, shifting=0. Then assert reset_n=0 mid-SHIFT -> all outputs return to reset values immediately.
- button_press=9 (A), 12us latch, then 16 clocks at 6us -> sampled bits 0..15 = 1,1,1,1,1,1,1,1,0,1,1,1,1,1,1,1; data=0 after the 16th rise; one frame_strobe pulse.
- button_press=1 for one frame, then 0 for 4 frames, HOLD_FRAMES=2 -> B reads pressed (bit0=0) in frames 1,2,3 and released in frames 4,5.
- button_press=14 -> all 16 bits read 1. Code 0 with hold_cnt=0 -> all 1.
- Latch reasserted after 7 clocks -> FSM in LOAD, bit0 re-presented, no stale shift. 20 clocks after a latch -> data=0 after the 16th, stays 0.
- Latch fall followed by a clock stall of 2048 clk -> FSM returns to IDLE, snes_data=1. The next latch then yields a full correct frame.

Source files
------------

// File: rtl/snes_serializer.sv
// snes_serializer
// Presents the arbitrated 4-bit button code to an SNES console as a
// standard controller. Console strobes are synchronised, a decoded press
// is stretched across HOLD_FRAMES extra latch frames, and aborted or
// stalled polls are recovered.
//
// Ports:
//   clk          system clock (12 MHz nominal)
//   reset_n      asynchronous active-low reset
//   button_press arbitrated button code, sampled on each latch rise
//   snes_latch   console latch, asynchronous, active-high
//   snes_clock   console data clock, asynchronous, idles high
//   snes_data    serial data to the console, active-low (0 = pressed)
//   frame_strobe one-cycle pulse when the latch falls (frame start)
//   shifting     high while the serializer is in SHIFT
module snes_serializer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_FRAMES    = 2,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] button_press,
  input  logic       snes_latch,
  input  logic       snes_clock,
  output logic       snes_data,
  output logic       frame_strobe,
  output logic       shifting
);

  localparam int HCW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam int TW  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_clock_sync;
  logic                   r_latch_d;
  logic                   r_clock_d;
  logic [1:0]             r_state;
  logic [15:0]            r_sr;
  logic [4:0]             r_bit_cnt;
  logic [TW-1:0]          r_timeout;
  logic [HCW-1:0]         r_hold_cnt;
  logic [11:0]            r_held_vec;
  logic                   r_data;
  logic                   r_frame_strobe;
  logic                   r_shifting;

  logic                   w_latch_s;
  logic                   w_clock_s;
  logic                   w_latch_rise;
  logic                   w_latch_fall;
  logic                   w_clock_rise;
  logic                   w_code_valid;
  logic [11:0]            w_decoded;
  logic [11:0]            w_held_next;
  logic [HCW-1:0]         w_hold_cnt_next;
  logic                   w_timeout_hit;
  logic [1:0]             w_state_next;

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_clock_s    = r_clock_sync[SYNC_STAGES-1];
  assign w_latch_rise = w_latch_s & ~r_latch_d;
  assign w_latch_fall = ~w_latch_s & r_latch_d;
  assign w_clock_rise = w_clock_s & ~r_clock_d;

  assign w_code_valid  = (button_press != 4'd0) && (button_press <= 4'd12);
  assign w_timeout_hit = (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  // Decode and hold evaluation; only committed on a latch rise.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    w_decoded       = '0;
    w_held_next     = r_held_vec;
    w_hold_cnt_next = r_hold_cnt;
    if (w_code_valid) begin
      w_decoded[button_press - 4'd1] = 1'b1;
    end
    if (w_code_valid) begin
      w_held_next     = w_decoded;
      w_hold_cnt_next = HCW'(HOLD_FRAMES);
    end else if (r_hold_cnt != '0) begin
      w_hold_cnt_next = r_hold_cnt - 1'b1;
    end else begin
      w_held_next = '0;
    end
  end

  // A latch rise restarts the frame from any state and beats a
  // same-cycle clock edge.
  always_comb begin
    w_state_next = r_state;
    if (w_latch_rise) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (w_latch_fall) w_state_next = ST_SHIFT;
        ST_SHIFT: begin
          if (w_clock_rise) begin
            if (r_bit_cnt == 5'd15) w_state_next = ST_DONE;
          end else if (w_timeout_hit) begin
            w_state_next = ST_IDLE;
          end
        end
        default:  w_state_next = r_state;
      endcase
    end
  end

  // NOTE: the whole datapath (including the shift register) is reset so
  // the console sees a released pad straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_sync   <= '0;
      r_clock_sync   <= '1;
      r_latch_d      <= 1'b0;
      r_clock_d      <= 1'b1;
      r_state        <= ST_IDLE;
      r_sr           <= '0;
      r_bit_cnt      <= '0;
      r_timeout      <= '0;
      r_hold_cnt     <= '0;
      r_held_vec     <= '0;
      r_data         <= 1'b1;
      r_frame_strobe <= 1'b0;
      r_shifting     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples
      // the pre-edge values and the synchroniser really is a chain.
      r_latch_sync   <= {r_latch_sync[SYNC_STAGES-2:0], snes_latch};
      r_clock_sync   <= {r_clock_sync[SYNC_STAGES-2:0], snes_clock};
      r_latch_d      <= w_latch_s;
      r_clock_d      <= w_clock_s;
      r_state        <= w_state_next;
      r_shifting     <= (w_state_next == ST_SHIFT);
      r_frame_strobe <= 1'b0;

      if (w_latch_rise) begin
        r_held_vec <= w_held_next;
        r_hold_cnt <= w_hold_cnt_next;
        r_sr       <= {4'b0000, w_held_next};
        r_data     <= ~w_held_next[0];
      end else begin
        case (r_state)
          ST_IDLE: r_data <= 1'b1;
          ST_LOAD: begin
            r_data <= ~r_sr[0];
            if (w_latch_fall) begin
              r_bit_cnt      <= '0;
              r_timeout      <= '0;
              r_frame_strobe <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (w_clock_rise) begin
              // Fill with "pressed" so the line reads 0 once all 16 bits
              // have gone, as a genuine controller does.
              r_sr      <= {1'b1, r_sr[15:1]};
              r_data    <= ~r_sr[1];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_timeout <= '0;
            end else if (w_timeout_hit) begin
              r_data    <= 1'b1;
              r_timeout <= '0;
            end else begin
              r_timeout <= r_timeout + 1'b1;
            end
          end
          default: r_data <= 1'b0;
        endcase
      end
    end
  end

  assign snes_data    = r_data;
  assign frame_strobe = r_frame_strobe;
  assign shifting     = r_shifting;

endmodule
